// File: rtl/ccip_c1tx_wr_shaper.sv
// CCI-P c1 Tx write shaper: queues upstream write requests, drops low addresses,
// and issues registered writes subject to almost-full and an outstanding-write cap.
module ccip_c1tx_wr_shaper #(
    parameter int unsigned DEPTH           = 16,
    parameter int unsigned MAX_OUTSTANDING = 64,
    parameter logic [41:0] MIN_ADDR        = 42'h100
) (
    input  logic         pClk,
    input  logic         pck_cp2af_softReset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [41:0]  in_addr,
    input  logic [511:0] in_data,
    input  logic         c1TxAlmFull,
    input  logic         c1Rx_rspValid,
    output logic         c1Tx_valid,
    output logic [41:0]  c1Tx_addr,
    output logic [511:0] c1Tx_data,
    output logic [6:0]   outstanding,
    output logic [15:0]  drop_cnt,
    output logic         err_low_addr,
    output logic         err_underflow,
    output logic         idle
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [7:0]  MAX_OUT = 8'(MAX_OUTSTANDING);

    logic [41:0]  mem_addr [DEPTH];
    logic [511:0] mem_data [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    logic        fifo_empty;
    logic        fifo_full;
    logic        accept;
    logic        low_addr;
    logic        push;
    logic        pop;
    logic [7:0]  in_flight;
    logic [6:0]  outstanding_nxt;
    logic        underflow_set;

    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                        (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;
    assign low_addr = (in_addr <= MIN_ADDR);
    assign push     = accept && !low_addr;

    // The registered issue currently on c1Tx is not yet in outstanding; count it
    // here so the cap can never be overshot.
    assign in_flight = {1'b0, outstanding} + {7'b0, c1Tx_valid};
    assign pop       = !fifo_empty && !c1TxAlmFull && (in_flight < MAX_OUT);

    assign idle = fifo_empty && (outstanding == 7'd0) && !c1Tx_valid;

    always_comb begin
        outstanding_nxt = outstanding;
        underflow_set   = 1'b0;
        case ({c1Tx_valid, c1Rx_rspValid})
            2'b10: outstanding_nxt = outstanding + 7'd1;
            2'b01: begin
                if (outstanding == 7'd0) begin
                    underflow_set = 1'b1;
                end else begin
                    outstanding_nxt = outstanding - 7'd1;
                end
            end
            default: outstanding_nxt = outstanding;
        endcase
    end

    // Storage needs no reset; pointers alone define validity.
    always_ff @(posedge pClk) begin
        if (push) begin
            mem_addr[wr_ptr[AW-1:0]] <= in_addr;
            mem_data[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge pClk or posedge pck_cp2af_softReset) begin
        if (pck_cp2af_softReset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            c1Tx_valid    <= 1'b0;
            c1Tx_addr     <= '0;
            c1Tx_data     <= '0;
            outstanding   <= '0;
            drop_cnt      <= '0;
            err_low_addr  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            c1Tx_valid <= pop;
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                c1Tx_addr <= mem_addr[rd_ptr[AW-1:0]];
                c1Tx_data <= mem_data[rd_ptr[AW-1:0]];
            end
            outstanding <= outstanding_nxt;
            if (accept && low_addr) begin
                err_low_addr <= 1'b1;
                if (drop_cnt != 16'hFFFF) begin
                    drop_cnt <= drop_cnt + 16'd1;
                end
            end
            if (underflow_set) begin
                err_underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ccip_c1tx_wr_shaper.sv
// Directed bench for ccip_c1tx_wr_shaper: default instance plus a MAX_OUTSTANDING=4 instance
// sharing the same stimulus.
module tb_ccip_c1tx_wr_shaper;

    logic         pClk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [41:0]  in_addr;
    logic [511:0] in_data;
    logic         almfull;
    logic         rsp;

    logic         ready_a, valid_a, lowerr_a, underr_a, idle_a;
    logic [41:0]  addr_a;
    logic [511:0] data_a;
    logic [6:0]   out_a;
    logic [15:0]  drop_a;

    logic         ready_b, valid_b, lowerr_b, underr_b, idle_b;
    logic [41:0]  addr_b;
    logic [511:0] data_b;
    logic [6:0]   out_b;
    logic [15:0]  drop_b;

    int n_cmp = 0;
    int n_err = 0;

    always #5 pClk = ~pClk;

    ccip_c1tx_wr_shaper dut_a (
        .pClk(pClk), .pck_cp2af_softReset(rst),
        .in_valid(in_valid), .in_ready(ready_a), .in_addr(in_addr), .in_data(in_data),
        .c1TxAlmFull(almfull), .c1Rx_rspValid(rsp),
        .c1Tx_valid(valid_a), .c1Tx_addr(addr_a), .c1Tx_data(data_a),
        .outstanding(out_a), .drop_cnt(drop_a),
        .err_low_addr(lowerr_a), .err_underflow(underr_a), .idle(idle_a)
    );

    ccip_c1tx_wr_shaper #(.MAX_OUTSTANDING(4)) dut_b (
        .pClk(pClk), .pck_cp2af_softReset(rst),
        .in_valid(in_valid), .in_ready(ready_b), .in_addr(in_addr), .in_data(in_data),
        .c1TxAlmFull(almfull), .c1Rx_rspValid(rsp),
        .c1Tx_valid(valid_b), .c1Tx_addr(addr_b), .c1Tx_data(data_b),
        .outstanding(out_b), .drop_cnt(drop_b),
        .err_low_addr(lowerr_b), .err_underflow(underr_b), .idle(idle_b)
    );

    function automatic logic [511:0] mkdata(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 ^ 32'(i);
        return {16{w}};
    endfunction

    task automatic tick();
        @(posedge pClk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; almfull = 1'b0; rsp = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        n_cmp++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL %s in_ready got %b exp 1", tag, ready_a); end
        n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL %s c1Tx_valid got %b exp 0", tag, valid_a); end
        n_cmp++; if (addr_a !== 42'h0) begin n_err++; $display("FAIL %s c1Tx_addr got %h exp 0", tag, addr_a); end
        n_cmp++; if (data_a !== 512'h0) begin n_err++; $display("FAIL %s c1Tx_data nonzero", tag); end
        n_cmp++; if (out_a !== 7'd0) begin n_err++; $display("FAIL %s outstanding got %0d exp 0", tag, out_a); end
        n_cmp++; if (drop_a !== 16'd0) begin n_err++; $display("FAIL %s drop_cnt got %0d exp 0", tag, drop_a); end
        n_cmp++; if (lowerr_a !== 1'b0) begin n_err++; $display("FAIL %s err_low_addr got %b exp 0", tag, lowerr_a); end
        n_cmp++; if (underr_a !== 1'b0) begin n_err++; $display("FAIL %s err_underflow got %b exp 0", tag, underr_a); end
        n_cmp++; if (idle_a !== 1'b1) begin n_err++; $display("FAIL %s idle got %b exp 1", tag, idle_a); end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_addr = '0; in_data = '0; almfull = 1'b0; rsp = 1'b0;
        #1;
        check_reset_vals("reset");
        tick();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        in_valid = 1'b1; in_addr = 42'h200; in_data = mkdata(7);
        tick();
        in_valid = 1'b0;
        n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL basic_no_bypass valid got %b exp 0", valid_a); end
        tick();
        n_cmp++; if (valid_a !== 1'b1) begin n_err++; $display("FAIL basic_valid got %b exp 1", valid_a); end
        n_cmp++; if (addr_a !== 42'h200) begin n_err++; $display("FAIL basic_addr got %h exp 200", addr_a); end
        n_cmp++; if (data_a !== mkdata(7)) begin n_err++; $display("FAIL basic_data got %h exp %h", data_a[31:0], 32'hC0DE0007); end
        tick();
        n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL basic_single_issue valid got %b exp 0", valid_a); end
        n_cmp++; if (out_a !== 7'd1) begin n_err++; $display("FAIL basic_outstanding got %0d exp 1", out_a); end
        n_cmp++; if (idle_a !== 1'b0) begin n_err++; $display("FAIL basic_busy idle got %b exp 0", idle_a); end
        rsp = 1'b1;
        tick();
        rsp = 1'b0;
        n_cmp++; if (out_a !== 7'd0) begin n_err++; $display("FAIL basic_rsp outstanding got %0d exp 0", out_a); end
        n_cmp++; if (idle_a !== 1'b1) begin n_err++; $display("FAIL basic_idle got %b exp 1", idle_a); end
        n_cmp++; if (underr_a !== 1'b0) begin n_err++; $display("FAIL basic_underflow got %b exp 0", underr_a); end
    endtask

    task automatic test_almfull();
        do_reset();
        almfull = 1'b1;
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL almfull_ready[%0d] got %b exp 1", i, ready_a); end
            in_valid = 1'b1; in_addr = 42'h1000 + 42'(i); in_data = mkdata(i);
            tick();
            n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL almfull_blocked[%0d] valid got %b exp 0", i, valid_a); end
        end
        in_valid = 1'b0;
        n_cmp++; if (ready_a !== 1'b0) begin n_err++; $display("FAIL almfull_full in_ready got %b exp 0", ready_a); end
        tick();
        n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL almfull_hold valid got %b exp 0", valid_a); end
        almfull = 1'b0;
        tick();
        for (int i = 0; i < 16; i++) begin
            n_cmp++; if (valid_a !== 1'b1) begin n_err++; $display("FAIL drain_valid[%0d] got %b exp 1", i, valid_a); end
            n_cmp++; if (addr_a !== 42'h1000 + 42'(i)) begin n_err++; $display("FAIL drain_addr[%0d] got %h exp %h", i, addr_a, 42'h1000 + 42'(i)); end
            n_cmp++; if (data_a !== mkdata(i)) begin n_err++; $display("FAIL drain_data[%0d] got %h exp %h", i, data_a[31:0], 32'hC0DE0000 ^ 32'(i)); end
            tick();
        end
        n_cmp++; if (valid_a !== 1'b0) begin n_err++; $display("FAIL drain_end valid got %b exp 0", valid_a); end
        n_cmp++; if (out_a !== 7'd16) begin n_err++; $display("FAIL drain_outstanding got %0d exp 16", out_a); end
        n_cmp++; if (ready_a !== 1'b1) begin n_err++; $display("FAIL drain_ready got %b exp 1", ready_a); end
    endtask

    task automatic test_low_addr();
        int cnt;
        logic [41:0] last;
        do_reset();
        cnt = 0; last = '0;
        in_valid = 1'b1; in_addr = 42'h100; in_data = mkdata(1);
        tick();
        in_addr = 42'h101; in_data = mkdata(2);
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (valid_a === 1'b1) begin cnt++; last = addr_a; end
            tick();
        end
        n_cmp++; if (cnt !== 1) begin n_err++; $display("FAIL low_issue_count got %0d exp 1", cnt); end
        n_cmp++; if (last !== 42'h101) begin n_err++; $display("FAIL low_issue_addr got %h exp 101", last); end
        n_cmp++; if (drop_a !== 16'd1) begin n_err++; $display("FAIL low_drop_cnt got %0d exp 1", drop_a); end
        n_cmp++; if (lowerr_a !== 1'b1) begin n_err++; $display("FAIL low_err got %b exp 1", lowerr_a); end
    endtask

    task automatic test_max_outstanding();
        int cnt;
        do_reset();
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; in_addr = 42'h2000 + 42'(i); in_data = mkdata(100 + i);
            tick();
            if (valid_b === 1'b1) begin
                n_cmp++; if (addr_b !== 42'h2000 + 42'(cnt)) begin n_err++; $display("FAIL cap_order got %h exp %h", addr_b, 42'h2000 + 42'(cnt)); end
                cnt++;
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid_b === 1'b1) cnt++;
        end
        n_cmp++; if (cnt !== 4) begin n_err++; $display("FAIL cap_issue_count got %0d exp 4", cnt); end
        n_cmp++; if (out_b !== 7'd4) begin n_err++; $display("FAIL cap_outstanding got %0d exp 4", out_b); end
        rsp = 1'b1;
        tick();
        rsp = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid_b === 1'b1) begin
                cnt++;
                n_cmp++; if (addr_b !== 42'h2004) begin n_err++; $display("FAIL cap_next_addr got %h exp 2004", addr_b); end
            end
        end
        n_cmp++; if (cnt !== 1) begin n_err++; $display("FAIL cap_one_more got %0d exp 1", cnt); end
        n_cmp++; if (out_b !== 7'd4) begin n_err++; $display("FAIL cap_outstanding_after got %0d exp 4", out_b); end
    endtask

    task automatic test_underflow();
        do_reset();
        rsp = 1'b1;
        tick();
        rsp = 1'b0;
        n_cmp++; if (underr_a !== 1'b1) begin n_err++; $display("FAIL underflow_flag got %b exp 1", underr_a); end
        n_cmp++; if (out_a !== 7'd0) begin n_err++; $display("FAIL underflow_outstanding got %0d exp 0", out_a); end
        in_valid = 1'b1; in_addr = 42'h300; in_data = mkdata(30);
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        n_cmp++; if (out_a !== 7'd1) begin n_err++; $display("FAIL coinc_setup outstanding got %0d exp 1", out_a); end
        in_valid = 1'b1; in_addr = 42'h301; in_data = mkdata(31);
        tick();
        in_valid = 1'b0;
        tick();
        n_cmp++; if (valid_a !== 1'b1) begin n_err++; $display("FAIL coinc_valid got %b exp 1", valid_a); end
        rsp = 1'b1;
        tick();
        rsp = 1'b0;
        n_cmp++; if (out_a !== 7'd1) begin n_err++; $display("FAIL coinc_outstanding got %0d exp 1", out_a); end
        n_cmp++; if (underr_a !== 1'b1) begin n_err++; $display("FAIL underflow_sticky got %b exp 1", underr_a); end
    endtask

    task automatic test_reset_mid();
        int cnt;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_addr = 42'h400 + 42'(i); in_data = mkdata(40 + i);
            tick();
        end
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_cmp++; if (out_a !== 7'd3) begin n_err++; $display("FAIL mid_setup outstanding got %0d exp 3", out_a); end
        almfull = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_addr = 42'h500 + 42'(i); in_data = mkdata(50 + i);
            tick();
        end
        in_valid = 1'b0;
        n_cmp++; if (idle_a !== 1'b0) begin n_err++; $display("FAIL mid_setup idle got %b exp 0", idle_a); end
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("mid_reset");
        tick();
        rst = 1'b0;
        almfull = 1'b0;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (valid_a === 1'b1) cnt++;
        end
        n_cmp++; if (cnt !== 0) begin n_err++; $display("FAIL mid_no_issue got %0d exp 0", cnt); end
        n_cmp++; if (idle_a !== 1'b1) begin n_err++; $display("FAIL mid_idle got %b exp 1", idle_a); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_almfull();
        test_low_addr();
        test_max_outstanding();
        test_underflow();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
